// File: rtl/delay_timer_arbiter.sv
// delay_timer_arbiter: one prescaled delay timer shared round-robin among NREQ requesters.
// Define DELAY_TIMER_ARBITER_CANCEL_EN to abort a run when the granted requester drops req.
module delay_timer_arbiter #(
    parameter int NREQ     = 4,
    parameter int TICK_DIV = 50000,
    parameter int DW       = 16
) (
    input  logic                 clk,
    input  logic                 aclr,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*DW-1:0]   delay,
    output logic [NREQ-1:0]      gnt,
    output logic [NREQ-1:0]      done,
    output logic                 busy,
    output logic                 tick
);
    localparam int IW = $clog2(NREQ);
    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state;
    logic [PW-1:0] presc;
    logic [DW-1:0] cnt;
    logic [IW-1:0] last;
    logic [IW-1:0] nxt;
    logic          found;
    logic          fin;

    assign tick = (state == RUN) && (presc == PMAX);
    // a zero delay finishes without waiting for a tick
    assign fin  = (cnt == '0) || (tick && cnt == DW'(1));

    // lowest offset from last+1 wins, so scan offsets downward and let later hits override
    always_comb begin
        nxt   = last;
        found = 1'b0;
        for (int o = NREQ; o >= 1; o--) begin
            if (req[(int'(last) + o) % NREQ]) begin
                nxt   = IW'((int'(last) + o) % NREQ);
                found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge aclr) begin
        if (!aclr) begin
            state <= IDLE;
            gnt   <= '0;
            done  <= '0;
            busy  <= 1'b0;
            presc <= '0;
            cnt   <= '0;
            last  <= IW'(NREQ - 1);
        end else begin
            done <= '0;
            case (state)
                IDLE: begin
                    if (found) begin
                        state <= RUN;
                        gnt   <= NREQ'(1) << nxt;
                        busy  <= 1'b1;
                        presc <= '0;
                        cnt   <= delay[int'(nxt)*DW +: DW];
                        last  <= nxt;
                    end
                end
                RUN: begin
                    presc <= (presc == PMAX) ? '0 : presc + 1'b1;
                    if (tick && cnt != '0) cnt <= cnt - 1'b1;
`ifdef DELAY_TIMER_ARBITER_CANCEL_EN
                    if ((req & gnt) == '0) begin
                        state <= IDLE;
                        gnt   <= '0;
                        busy  <= 1'b0;
                    end else if (fin) begin
                        state <= DONE;
                        done  <= gnt;
                        gnt   <= '0;
                    end
`else
                    if (fin) begin
                        state <= DONE;
                        done  <= gnt;
                        gnt   <= '0;
                    end
`endif
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_delay_timer_arbiter.sv
// tb_delay_timer_arbiter: vector table plus scoreboard of expected done events (requester, latency, tick count).
module tb_delay_timer_arbiter;
    localparam int NREQ = 4;
    localparam int TD   = 4;
    localparam int DW   = 8;

    logic        clk   = 1'b0;
    logic        aclr  = 1'b0;
    logic [3:0]  req   = '0;
    logic [31:0] delay = '0;
    logic [3:0]  gnt;
    logic [3:0]  done;
    logic        busy;
    logic        tick;

    delay_timer_arbiter #(.NREQ(NREQ), .TICK_DIV(TD), .DW(DW)) dut (
        .clk(clk), .aclr(aclr), .req(req), .delay(delay),
        .gnt(gnt), .done(done), .busy(busy), .tick(tick)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int idx; int lat; int ticks; } exp_t;
    typedef struct { logic [3:0] r; logic [31:0] d; int idx; int dly; } vec_t;

    exp_t       sbq[$];
    vec_t       vt[5];
    int         ncmp = 0;
    int         nerr = 0;
    int         gcyc = 0;
    int         tcnt = 0;
    logic [3:0] pg   = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        ncmp++;
        if (act !== want) begin
            nerr++;
            $display("FAIL %s: got %0d, want %0d (cycle %0d)", nm, act, want, cyc);
        end
    endtask

    task automatic push_exp(input int idx, input int dly);
        exp_t e;
        e.idx   = idx;
        e.lat   = (dly == 0) ? 1 : dly * TD;
        e.ticks = dly;
        sbq.push_back(e);
    endtask

    // advance one cycle and score whatever grant/done events the DUT produced
    task automatic step();
        exp_t e;
        @(negedge clk);
        if (gnt != '0 && pg == '0) begin
            gcyc = cyc;
            tcnt = 0;
            if (sbq.size() != 0) chk("grant", gnt, 4'b1 << sbq[0].idx);
            chk("busy_at_grant", busy, 1);
        end
        if (tick) tcnt++;
        if (done != '0) begin
            if (sbq.size() == 0) chk("unexpected_done", done, 0);
            else begin
                e = sbq.pop_front();
                chk("done_bit", done, 4'b1 << e.idx);
                chk("done_latency", cyc - gcyc, e.lat);
                chk("tick_count", tcnt, e.ticks);
                chk("gnt_clear_at_done", gnt, 0);
            end
        end
        pg = gnt;
    endtask

    task automatic wait_done(input int lim);
        for (int n = 0; n < lim && sbq.size() != 0; n++) step();
        if (sbq.size() != 0) begin
            chk("timeout_pending", sbq.size(), 0);
            sbq.delete();
        end
    endtask

    task automatic finish_run();
        chk("busy_in_done", busy, 1);
        req = '0;
        step();
        chk("busy_idle", busy, 0);
        chk("done_one_cycle", done, 0);
    endtask

    initial begin
        vt[0] = '{4'b0001, 32'h0000_0003, 0, 3};
        vt[1] = '{4'b0100, 32'h1100_0022, 2, 0};
        vt[2] = '{4'b0010, 32'h0000_0200, 1, 2};
        vt[3] = '{4'b1000, 32'hff00_0000, 3, 255};
        vt[4] = '{4'b1010, 32'h0900_0500, 1, 5};

        repeat (2) step();
        chk("reset_gnt", gnt, 0);
        chk("reset_done", done, 0);
        chk("reset_busy", busy, 0);
        chk("reset_tick", tick, 0);
        aclr = 1'b1;
        step();

        delay = 32'h0101_0101;
        push_exp(0, 1); push_exp(1, 1); push_exp(2, 1); push_exp(3, 1); push_exp(0, 1);
        req = 4'hf;
        wait_done(200);
        finish_run();

        for (int i = 0; i < 5; i++) begin
            req   = vt[i].r;
            delay = vt[i].d;
            push_exp(vt[i].idx, vt[i].dly);
            wait_done(1100);
            finish_run();
        end

        req   = 4'b0010;
        delay = 32'h0000_0400;
`ifndef DELAY_TIMER_ARBITER_CANCEL_EN
        push_exp(1, 4);
`endif
        step();
        chk("cancel_grant", gnt, 4'b0010);
        repeat (5) step();
        req   = '0;
        delay = '0;
`ifdef DELAY_TIMER_ARBITER_CANCEL_EN
        step();
        chk("cancel_gnt_clear", gnt, 0);
        chk("cancel_busy_clear", busy, 0);
        repeat (20) step();
`else
        wait_done(100);
        finish_run();
`endif

        req   = 4'b0001;
        delay = 32'h0000_0003;
        step();
        chk("pre_reset_grant", gnt, 4'b0001);
        repeat (5) step();
        aclr = 1'b0;
        req  = '0;
        #1;
        chk("abort_gnt", gnt, 0);
        chk("abort_done", done, 0);
        chk("abort_busy", busy, 0);
        chk("abort_tick", tick, 0);
        step();
        aclr  = 1'b1;
        req   = 4'b1000;
        delay = 32'h0200_0000;
        push_exp(3, 2);
        wait_done(100);
        finish_run();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule

// File: doc/delay_timer_arbiter.md
# delay_timer_arbiter

Shares one prescaled delay timer among NREQ requesters. Each requester asks for a delay of D ticks. The block grants the timer round-robin, runs the countdown on a prescaler derived from clk, and pulses a per-requester done. It sits between CLOCK_50 and the LED and sequencing blocks, so they no longer each instantiate a private multi-million-count delay counter.

## Interface
Parameters:
- NREQ, 4, number of requesters (2..8)
- TICK_DIV, 50000, clk cycles per tick (1 ms at 50 MHz); must be >= 2
- DW, 16, width of each delay request, in ticks

Ports:
- clk  in  1  system clock
- aclr  in  1  asynchronous active-low reset
- req  in  NREQ  request level, one per requester; hold until done
- delay  in  NREQ*DW  packed delays; requester i uses bits [i*DW +: DW]
- gnt  out  NREQ  one-hot grant, high for the whole RUN phase
- done  out  NREQ  one-cycle completion pulse to the granted requester
- busy  out  1  timer owned (state RUN or DONE)
- tick  out  1  prescaler tick, high one cycle every TICK_DIV cycles while in RUN

## Operation
- Reset (aclr low, asynchronous) sets:
  - state IDLE
  - gnt=0, done=0, busy=0, tick=0
  - prescaler=0, countdown=0
  - last-grant pointer = NREQ-1, so requester 0 has first priority
- States:
  - IDLE: if req != 0, select the first asserted req searching from last+1 upward, wrapping modulo NREQ. Latch that requester's delay into the countdown, set gnt one-hot, clear the prescaler, set last = winner, go to RUN. If req == 0, stay in IDLE.
  - RUN:
    - The prescaler counts 0..TICK_DIV-1 and wraps. tick = (prescaler == TICK_DIV-1).
    - On tick, countdown decrements.
    - When tick and countdown==1 → DONE.
    - Latched delay of 0 → DONE on the next edge without waiting for a tick.
  - DONE: done[winner]=1 for exactly one cycle, gnt cleared at the same edge, then IDLE.
- Back-to-back: a requester still holding req in IDLE competes normally. Round-robin means another pending requester wins first.
- The delay input is sampled only at grant. Changes during RUN are ignored.
- Countdown arithmetic is unsigned DW-bit. The maximum delay 2^DW-1 is valid. There is no wrap, because decrement only occurs while countdown >= 1.
- Requests arriving during RUN or DONE wait. None are lost, since req is a level.
- Reset mid-RUN aborts immediately: no done, and gnt drops asynchronously.

## Timing
- The grant decision is taken in one cycle: IDLE→RUN on the first edge where req is seen.
- gnt[i] rises at edge k. done[i] is high during the cycle following edge k + D*TICK_DIV for D ≥ 1, or edge k+1 for D=0.
- Minimum turnaround per grant, including the DONE and IDLE cycles: D*TICK_DIV + 2 cycles.
- All outputs are registered except tick, which is decoded from the prescaler and state.
- busy = (state != IDLE).

## Configuration
- Macro: DELAY_TIMER_ARBITER_CANCEL_EN.
- Defined: if req[winner] falls during RUN, the run is cancelled. The block returns to IDLE at the next edge, gnt clears, no done is issued, and last = winner.
- Undefined: req is ignored after grant, and the run always completes with a done pulse.

## Test plan
Bench settings: TICK_DIV=4, NREQ=4, DW=8.
- Single request, delay=3: req=0001 → gnt=0001 next edge; done[0] pulses once exactly 12 cycles after gnt rises; busy is high from gnt until after done.
- Round-robin: req=1111 held, all delays=1 → grants in order 0,1,2,3,0, each done 4 cycles after its grant, never two bits of gnt high.
- Zero delay: req=0100, delay=0 → gnt=0100, done[2] pulses 1 cycle later, and tick never asserts.
- Max delay 255: done arrives after 1020 cycles, with no early done and no countdown wrap.
- Cancel: req[1] dropped 5 cycles into a delay=4 run → with the macro defined, gnt clears next edge and there is no done; without it, done[1] pulses at cycle 16.
- Reset mid-RUN: aclr low for 1 cycle at cycle 6 → all outputs 0 immediately; a subsequent req=1000 grants requester 3 from a clean prescaler.
